uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
UART receiver, 8N1, with a 16x oversampling bit-slicer and a byte FIFO. It is the receiving end of the SoC's o_uart_tx line, used on-fabric for loopback checking and for host bridge logic that consumes console output. It delivers bytes on a valid/ready stream and reports sticky framing and overrun errors.

Parameters:
BAUD_DIV, 27, clk cycles per oversample tick (clk / (baud*16)); legal range 1..65535
FIFO_DEPTH, 16, FIFO entries; must be a power of 2, at least 2
LVL_W, 5, log2(FIFO_DEPTH)+1

Ports:
clk  in  1  single clock
rstn  in  1  asynchronous active-low reset
i_uart_rx  in  1  serial line; idles high; asynchronous to clk
o_data  out  8  FIFO head byte
o_valid  out  1  FIFO not empty
i_ready  in  1  consumer accepts o_data when o_valid&&i_ready
o_level  out  LVL_W  FIFO occupancy, 0..FIFO_DEPTH
o_frame_err  out  1  sticky: stop bit sampled low
o_overrun  out  1  sticky: byte received while FIFO full
i_clr_err  in  1  clears both sticky flags

Behaviour:
- Reset (rstn=0, asynchronous): state IDLE; synchroniser flops =1; FIFO empty; o_valid=0, o_level=0, o_data=0, o_frame_err=0, o_overrun=0; tick counter=0. A reset mid-frame discards any partial byte.
- Synchroniser: 2 flops on i_uart_rx, giving rx_s. A falling edge is detected from rx_s and its registered copy.
- Tick generator: free-running counter 0..BAUD_DIV-1. tick=1 for one cycle when the count equals BAUD_DIV-1, then the count wraps to 0. The counter is reset on entry to START.
- Oversample counter os (4 bits) advances on each tick. A bit sample is taken when os==7 (mid-bit). os wraps 15->0.
- FSM:
  - IDLE: on an rx_s falling edge -> START; os=0.
  - START: at sample, if rx_s==0 -> DATA with bit index=0. If rx_s==1 (glitch) -> IDLE; nothing is pushed.
  - DATA: each sample shifts rx_s in LSB-first. After the 8th sample -> STOP (or PARITY, see Optional Feature).
  - STOP: at sample, if rx_s==1, push the byte and go to IDLE. If rx_s==0, set o_frame_err, discard the byte, and go to BRK.
  - BRK: wait for rx_s==1, then -> IDLE. This prevents a break condition from being re-read as a start bit.
- Push timing: o_valid rises the cycle after the STOP sample when the FIFO was empty. o_data is registered from the FIFO head.
- FIFO: pointers are LVL_W bits wide with wrap-around. full when level==FIFO_DEPTH; empty when level==0.
  - Pop: occurs when o_valid&&i_ready.
  - Push while full with no pop in the same cycle: byte dropped, o_overrun=1, FIFO contents unchanged.
  - Push and pop in the same cycle while full: push accepted, level unchanged.
  - Push and pop in the same cycle while empty: push only; pop is impossible since o_valid=0.
  - o_level reflects the post-update occupancy the cycle after the operation.
- Error flags:
  - Each flag sets on its event and stays set until i_clr_err=1.
  - If the set event and i_clr_err occur in the same cycle, set wins.
  - Errors do not stall reception.
- i_ready is ignored when o_valid=0.

Optional Feature:
UART_RX_PARITY_EN:
- Defined: frame is 8E1. After DATA the FSM enters PARITY and samples one extra bit.
- If the XOR of the 8 data bits and the parity bit is not 0, o_parity_err (an extra 1-bit sticky output, cleared by i_clr_err) is set and the byte is discarded at STOP.
- Not defined: 8N1 only; the PARITY state and the o_parity_err port do not exist.

Test Plan:
1. BAUD_DIV=4: send 0xA5 at 64 clk/bit, i_ready=0 -> o_valid=1, o_data=0xA5, o_level=1; no error flags set.
2. Send 0x00, 0xFF, 0x55 back-to-back with one stop bit each, i_ready=1 -> exactly three pops, in order, with matching data.
3. Low pulse of 3 clk on an idle line (glitch) -> no push; FSM returns to IDLE; o_level=0.
4. Send 0x3C with the stop bit held low for 2 bit times, then 0x81 normally -> o_frame_err=1, only 0x81 in the FIFO; i_clr_err clears the flag.
5. FIFO_DEPTH=16, i_ready=0, send 17 bytes -> o_level=16, o_overrun=1, head = first byte. Then assert i_ready exactly on the 17th push cycle -> push accepted, no overrun.
6. Assert rstn=0 mid-DATA of 0x7E, release, then send 0x12 -> only 0x12 is received; all outputs were at reset values during reset.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling and a byte FIFO on a valid/ready stream.
// Define UART_RX_PARITY_EN to receive 8E1 frames and add the sticky o_parity_err output.
module uart_rx_fifo #(
    parameter int BAUD_DIV   = 27,
    parameter int FIFO_DEPTH = 16,
    parameter int LVL_W      = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_uart_rx,
    output logic [7:0]       o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [LVL_W-1:0] o_level,
    output logic             o_frame_err,
    output logic             o_overrun,
`ifdef UART_RX_PARITY_EN
    output logic             o_parity_err,
`endif
    input  logic             i_clr_err
);

    localparam int AW = LVL_W - 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4,
        ST_BRK    = 3'd5
    } state_t;

    logic             sync1_q;
    logic             rx_s_q;
    logic             rx_prev_q;
    logic             fall_s;
    logic [15:0]      cnt_q;
    logic [3:0]       os_q;
    logic             tick_s;
    logic             sample_s;
    logic             start_s;
    state_t           state_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             stop_smp_s;
    logic             push_s;
    logic             frame_set_s;
    logic             ovr_set_s;
    logic             push_ok_s;
    logic             pop_s;
    logic             full_s;
    logic [LVL_W-1:0] wr_q;
    logic [LVL_W-1:0] rd_q;
    logic [LVL_W-1:0] wr_d;
    logic [LVL_W-1:0] rd_d;
    logic [LVL_W-1:0] level_q;
    logic             valid_q;
    logic [7:0]       data_q;
    logic [7:0]       data_d;
    logic             frame_q;
    logic             ovr_q;
    logic [7:0]       mem_q [FIFO_DEPTH];

    // Two-flop synchroniser plus delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= i_uart_rx;
            rx_s_q    <= sync1_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign fall_s   = rx_prev_q & ~rx_s_q;
    assign start_s  = (state_q == ST_IDLE) && fall_s;
    assign tick_s   = (cnt_q == 16'(BAUD_DIV - 1));
    assign sample_s = tick_s && (os_q == 4'd7);

    // Baud tick and oversample counters; both restart so os==7 lands mid start bit
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= 16'd0;
            os_q  <= 4'd0;
        end else if (start_s) begin
            cnt_q <= 16'd0;
            os_q  <= 4'd0;
        end else if (tick_s) begin
            cnt_q <= 16'd0;
            os_q  <= os_q + 4'd1;
        end else begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_q;
    logic par_bad_s;
    logic par_set_s;
    logic par_err_q;
`endif

    // Frame sequencer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fall_s) state_q <= ST_START;
                end
                ST_START: begin
                    if (sample_s) begin
                        bit_idx_q <= 3'd0;
                        state_q   <= rx_s_q ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (sample_s) begin
                        shift_q   <= {rx_s_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= ST_PARITY;
`else
                            state_q <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (sample_s) begin
                        par_q   <= rx_s_q;
                        state_q <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (sample_s) state_q <= rx_s_q ? ST_IDLE : ST_BRK;
                end
                ST_BRK: begin
                    if (rx_s_q) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign stop_smp_s  = (state_q == ST_STOP) && sample_s;
    assign frame_set_s = stop_smp_s && !rx_s_q;
`ifdef UART_RX_PARITY_EN
    assign par_bad_s = ^{shift_q, par_q};
    assign par_set_s = stop_smp_s && par_bad_s;
    assign push_s    = stop_smp_s && rx_s_q && !par_bad_s;
`else
    assign push_s    = stop_smp_s && rx_s_q;
`endif

    assign full_s    = ((wr_q - rd_q) == LVL_W'(FIFO_DEPTH));
    assign pop_s     = valid_q && i_ready;
    assign push_ok_s = push_s && (!full_s || pop_s);
    assign ovr_set_s = push_s && full_s && !pop_s;
    assign wr_d      = wr_q + {{(LVL_W-1){1'b0}}, push_ok_s};
    assign rd_d      = rd_q + {{(LVL_W-1){1'b0}}, pop_s};

    // Next head byte; a byte pushed into the slot becoming head bypasses the array
    always_comb begin
        data_d = data_q;
        if (wr_d == rd_d) begin
            data_d = data_q;
        end else if (push_ok_s && (rd_d[AW-1:0] == wr_q[AW-1:0])) begin
            data_d = shift_q;
        end else begin
            data_d = mem_q[rd_d[AW-1:0]];
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push_ok_s) mem_q[wr_q[AW-1:0]] <= shift_q;
    end

    // FIFO pointers and registered stream outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            valid_q <= 1'b0;
            data_q  <= 8'd0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= wr_d - rd_d;
            valid_q <= (wr_d != rd_d);
            data_q  <= data_d;
        end
    end

    // Sticky error flags; a set event outranks a clear in the same cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            frame_q <= frame_set_s ? 1'b1 : (i_clr_err ? 1'b0 : frame_q);
            ovr_q   <= ovr_set_s   ? 1'b1 : (i_clr_err ? 1'b0 : ovr_q);
        end
    end

`ifdef UART_RX_PARITY_EN
    // Sticky parity error flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_set_s ? 1'b1 : (i_clr_err ? 1'b0 : par_err_q);
        end
    end

    assign o_parity_err = par_err_q;
`endif

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_level     = level_q;
    assign o_frame_err = frame_q;
    assign o_overrun   = ovr_q;

endmodule
